// File: rtl/cam_pipe.sv
// cam_pipe: DEPTH-entry content-addressable memory with 1-cycle read and
// search responses and registered occupancy count / full / empty flags.
module cam_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  read_i,
  input  logic [DEPTH_LOG2-1:0] read_index_i,
  input  logic                  write_i,
  input  logic [DEPTH_LOG2-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  invalidate_i,
  input  logic [DEPTH_LOG2-1:0] invalidate_index_i,
  input  logic                  search_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_value_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic [DEPTH_LOG2-1:0] search_index_o,
  output logic                  search_multi_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_read_valid;
  logic [DATA_WIDTH-1:0] r_read_value;
  logic                  r_search_valid;
  logic                  r_search_hit;
  logic [DEPTH_LOG2-1:0] r_search_index;
  logic                  r_search_multi;

  logic [DEPTH-1:0]      w_match;
  logic                  w_hit;
  logic                  w_multi;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_add;
  logic                  w_sub;
  logic [DEPTH_LOG2:0]   w_count_next;

  // Parallel key compare against every valid entry; lowest match wins.
  always_comb begin
    w_hit   = 1'b0;
    w_multi = 1'b0;
    w_index = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_data[i] == search_data_i);
      if (w_match[i]) begin
        if (w_hit) begin
          w_multi = 1'b1;
        end else begin
          w_hit   = 1'b1;
          w_index = DEPTH_LOG2'(i);
        end
      end
    end
  end

  // Occupancy delta: a write to the invalidated index wins, so that
  // invalidate must not decrement.
  always_comb begin
    w_add        = write_i && !r_valid[write_index_i];
    w_sub        = invalidate_i && r_valid[invalidate_index_i] &&
                   !(write_i && (write_index_i == invalidate_index_i));
    w_count_next = r_count + (DEPTH_LOG2+1)'(w_add) - (DEPTH_LOG2+1)'(w_sub);
  end

  // Entry data storage; no reset needed since valid bits gate all use.
  always_ff @(posedge clk) begin
    if (!reset_i && write_i) begin
      r_data[write_index_i] <= write_data_i;
    end
  end

  // Valid bits and occupancy; write is applied after invalidate so it wins.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_valid <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (invalidate_i) begin
        r_valid[invalidate_index_i] <= 1'b0;
      end
      if (write_i) begin
        r_valid[write_index_i] <= 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_COUNT);
      r_empty <= (w_count_next == '0);
    end
  end

  // Read and search responses, sampled from pre-edge state.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_read_valid   <= 1'b0;
      r_read_value   <= '0;
      r_search_valid <= 1'b0;
      r_search_hit   <= 1'b0;
      r_search_index <= '0;
      r_search_multi <= 1'b0;
    end else begin
      r_read_valid   <= read_i && r_valid[read_index_i];
      r_read_value   <= (read_i && r_valid[read_index_i]) ? r_data[read_index_i] : '0;
      r_search_valid <= search_i;
      r_search_hit   <= search_i && w_hit;
      r_search_index <= search_i ? w_index : '0;
      r_search_multi <= search_i && w_multi;
    end
  end

  assign read_valid_o   = r_read_valid;
  assign read_value_o   = r_read_value;
  assign search_valid_o = r_search_valid;
  assign search_hit_o   = r_search_hit;
  assign search_index_o = r_search_index;
  assign search_multi_o = r_search_multi;
  assign count_o        = r_count;
  assign full_o         = r_full;
  assign empty_o        = r_empty;

endmodule

// File: tb/tb_cam_pipe.sv
// tb_cam_pipe: directed vectors with hand-computed expectations for cam_pipe.
module tb_cam_pipe;

  logic        clk;
  logic        reset_i;
  logic        read_i;
  logic [4:0]  read_index_i;
  logic        write_i;
  logic [4:0]  write_index_i;
  logic [31:0] write_data_i;
  logic        invalidate_i;
  logic [4:0]  invalidate_index_i;
  logic        search_i;
  logic [31:0] search_data_i;
  logic        read_valid_o;
  logic [31:0] read_value_o;
  logic        search_valid_o;
  logic        search_hit_o;
  logic [4:0]  search_index_o;
  logic        search_multi_o;
  logic [5:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int unsigned n_vec;
  int unsigned n_err;

  cam_pipe #(.DATA_WIDTH(32), .DEPTH_LOG2(5)) dut (
    .clk                (clk),
    .reset_i            (reset_i),
    .read_i             (read_i),
    .read_index_i       (read_index_i),
    .write_i            (write_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .invalidate_i       (invalidate_i),
    .invalidate_index_i (invalidate_index_i),
    .search_i           (search_i),
    .search_data_i      (search_data_i),
    .read_valid_o       (read_valid_o),
    .read_value_o       (read_value_o),
    .search_valid_o     (search_valid_o),
    .search_hit_o       (search_hit_o),
    .search_index_o     (search_index_o),
    .search_multi_o     (search_multi_o),
    .count_o            (count_o),
    .full_o             (full_o),
    .empty_o            (empty_o)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset_i            = 1'b0;
    read_i             = 1'b0;
    read_index_i       = '0;
    write_i            = 1'b0;
    write_index_i      = '0;
    write_data_i       = '0;
    invalidate_i       = 1'b0;
    invalidate_index_i = '0;
    search_i           = 1'b0;
    search_data_i      = '0;
  endtask

  // Apply current inputs at one edge, then sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    step();
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] d);
    write_i = 1'b1; write_index_i = idx; write_data_i = d;
    step();
  endtask

  task automatic do_read(input logic [4:0] idx);
    read_i = 1'b1; read_index_i = idx;
    step();
  endtask

  task automatic do_search(input logic [31:0] key);
    search_i = 1'b1; search_data_i = key;
    step();
  endtask

  task automatic check_search(input string tag, input logic v, input logic h,
                              input logic [4:0] idx, input logic m);
    check({tag, ".valid"}, 64'(search_valid_o), 64'(v));
    check({tag, ".hit"},   64'(search_hit_o),   64'(h));
    check({tag, ".index"}, 64'(search_index_o), 64'(idx));
    check({tag, ".multi"}, 64'(search_multi_o), 64'(m));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst.rvalid", 64'(read_valid_o), 64'(0));
    check("rst.rvalue", 64'(read_value_o), 64'(0));
    check_search("rst.s", 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst.count", 64'(count_o), 64'(0));
    check("rst.full",  64'(full_o),  64'(0));
    check("rst.empty", 64'(empty_o), 64'(1));

    // Write then read back
    do_write(5'd3, 32'hDEADBEEF);
    do_read(5'd3);
    check("rd3.valid", 64'(read_valid_o), 64'(1));
    check("rd3.value", 64'(read_value_o), 64'(32'hDEADBEEF));
    check("rd3.count", 64'(count_o), 64'(1));
    check("rd3.empty", 64'(empty_o), 64'(0));
    step();
    check("idle.rvalid", 64'(read_valid_o), 64'(0));
    check("idle.rvalue", 64'(read_value_o), 64'(0));

    // Multi-hit search and a miss
    do_write(5'd7, 32'hA5);
    do_write(5'd2, 32'hA5);
    do_search(32'hA5);
    check_search("sA5", 1'b1, 1'b1, 5'd2, 1'b1);
    do_search(32'h5A);
    check_search("s5A", 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    check_search("sidle", 1'b0, 1'b0, 5'd0, 1'b0);
    check("cnt3", 64'(count_o), 64'(3));

    // Same-cycle write is invisible to search
    do_reset();
    write_i = 1'b1; write_index_i = 5'd4; write_data_i = 32'h55;
    search_i = 1'b1; search_data_i = 32'h55;
    step();
    check_search("s55a", 1'b1, 1'b0, 5'd0, 1'b0);
    do_search(32'h55);
    check_search("s55b", 1'b1, 1'b1, 5'd4, 1'b0);

    // Invalidate hides entry from search and read
    invalidate_i = 1'b1; invalidate_index_i = 5'd4;
    step();
    check("inv4.count", 64'(count_o), 64'(0));
    check("inv4.empty", 64'(empty_o), 64'(1));
    do_search(32'h55);
    check_search("s55c", 1'b1, 1'b0, 5'd0, 1'b0);
    do_read(5'd4);
    check("rd4.valid", 64'(read_valid_o), 64'(0));
    check("rd4.value", 64'(read_value_o), 64'(0));
    invalidate_i = 1'b1; invalidate_index_i = 5'd4;
    step();
    check("inv4again.count", 64'(count_o), 64'(0));

    // Fill all entries
    do_reset();
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'(100 + i));
    check("fill.count", 64'(count_o), 64'(32));
    check("fill.full",  64'(full_o),  64'(1));
    check("fill.empty", 64'(empty_o), 64'(0));
    do_write(5'd0, 32'h1234);
    check("ovw.count", 64'(count_o), 64'(32));
    invalidate_i = 1'b1; invalidate_index_i = 5'd31;
    step();
    check("inv31.count", 64'(count_o), 64'(31));
    check("inv31.full",  64'(full_o),  64'(0));
    write_i = 1'b1; write_index_i = 5'd5; write_data_i = 32'h77;
    invalidate_i = 1'b1; invalidate_index_i = 5'd5;
    step();
    check("wi5.count", 64'(count_o), 64'(31));
    do_read(5'd5);
    check("wi5.rvalid", 64'(read_valid_o), 64'(1));
    check("wi5.rvalue", 64'(read_value_o), 64'(32'h77));
    do_search(32'd131);
    check_search("s131", 1'b1, 1'b0, 5'd0, 1'b0);

    // All four requests in one cycle: write 31, invalidate 10, read 0, search 110
    write_i = 1'b1; write_index_i = 5'd31; write_data_i = 32'hCAFE;
    invalidate_i = 1'b1; invalidate_index_i = 5'd10;
    read_i = 1'b1; read_index_i = 5'd0;
    search_i = 1'b1; search_data_i = 32'd110;
    step();
    check("all.rvalue", 64'(read_value_o), 64'(32'h1234));
    check_search("all.s", 1'b1, 1'b1, 5'd10, 1'b0);
    check("all.count", 64'(count_o), 64'(31));
    do_search(32'hCAFE);
    check_search("sCAFE", 1'b1, 1'b1, 5'd31, 1'b0);

    // Reset drops concurrent requests and pending responses
    do_reset();
    do_write(5'd9, 32'h99);
    read_i = 1'b1; read_index_i = 5'd9;
    search_i = 1'b1; search_data_i = 32'h99;
    step();
    reset_i = 1'b1;
    search_i = 1'b1; search_data_i = 32'h99;
    read_i = 1'b1; read_index_i = 5'd9;
    write_i = 1'b1; write_index_i = 5'd1; write_data_i = 32'h11;
    step();
    check_search("rsts", 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst2.rvalid", 64'(read_valid_o), 64'(0));
    check("rst2.count",  64'(count_o), 64'(0));
    check("rst2.empty",  64'(empty_o), 64'(1));
    do_read(5'd9);
    check("rd9.valid", 64'(read_valid_o), 64'(0));
    check("rd9.value", 64'(read_value_o), 64'(0));
    do_read(5'd1);
    check("rd1.valid", 64'(read_valid_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the stimulus never completes.
  initial begin
    #100000;
    $display("FAIL timeout: got stall expected completion");
    $fatal(1, "timeout");
  end

endmodule
